// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC and the
// read-only Config/PRId words, with a same-cycle write-to-read bypass.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;
  localparam logic [4:0] ADDR_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic        timerInt_q, timerInt_d;

  logic        timerMatch;
  logic        bypassHit;
  logic [31:0] causeMerged;

  assign timerMatch = (compare_q != 32'd0) && (count_q == compare_q);

  // Only IP[9:8], WP and IV are software-writable in Cause.
  always_comb begin
    causeMerged         = cause_q;
    causeMerged[9:8]    = data_i[9:8];
    causeMerged[23:22]  = data_i[23:22];
  end

  always_comb begin
    count_d         = count_q + 32'd1;
    compare_d       = compare_q;
    status_d        = status_q;
    cause_d         = cause_q;
    cause_d[15:10]  = int_i;
    epc_d           = epc_q;
    timerInt_d      = timerInt_q | timerMatch;
    if (we_i) begin
      case (waddr_i)
        ADDR_COUNT:   count_d = data_i;
        ADDR_COMPARE: begin
          compare_d  = data_i;
          timerInt_d = 1'b0;
        end
        ADDR_STATUS:  status_d = data_i;
        ADDR_CAUSE: begin
          cause_d[9:8]   = data_i[9:8];
          cause_d[23:22] = data_i[23:22];
        end
        ADDR_EPC:     epc_d = data_i;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      timerInt_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      timerInt_q <= timerInt_d;
    end
  end

  // A write in flight to the register being read is forwarded so execute sees it now.
  assign bypassHit = we_i && (waddr_i == raddr_i);

  always_comb begin
    data_o = 32'd0;
    if (!rst) begin
      case (raddr_i)
        ADDR_COUNT:   data_o = bypassHit ? data_i      : count_q;
        ADDR_COMPARE: data_o = bypassHit ? data_i      : compare_q;
        ADDR_STATUS:  data_o = bypassHit ? data_i      : status_q;
        ADDR_CAUSE:   data_o = bypassHit ? causeMerged : cause_q;
        ADDR_EPC:     data_o = bypassHit ? data_i      : epc_q;
        ADDR_PRID:    data_o = PRID_VALUE;
        ADDR_CONFIG:  data_o = CONFIG_VALUE;
        default:      data_o = 32'd0;
      endcase
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timerInt_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, timer, Cause masking, bypass,
// read-only/unmapped writes, Count wrap and simultaneous-event ordering.
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] data_o;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int checkCount = 0;
  int failCount  = 0;

  cp0_reg dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .raddr_i     (raddr_i),
    .int_i       (int_i),
    .data_o      (data_o),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .config_o    (config_o),
    .prid_o      (prid_o),
    .timer_int_o (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] waddr,
                               input logic [31:0] data, input logic [4:0] raddr);
    we_i    = we;
    waddr_i = waddr;
    data_i  = data;
    raddr_i = raddr;
    #1;
  endtask

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    int_i = 6'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd12);

    // Reset held for two cycles
    stepClock(1);
    checkOutput("rst_status", status_o, 32'h10000000);
    checkOutput("rst_cause",  cause_o,  32'd0);
    checkOutput("rst_count",  count_o,  32'd0);
    checkOutput("rst_timer",  {31'd0, timer_int_o}, 32'd0);
    checkOutput("rst_data",   data_o,   32'd0);
    checkOutput("rst_prid",   prid_o,   32'h004C0102);
    checkOutput("rst_config", config_o, 32'h00008000);
    stepClock(1);
    rst = 1'b0;
    stepClock(5);
    checkOutput("count_after5", count_o, 32'd5);
    checkOutput("read_status", data_o, 32'h10000000);

    // Timer: Compare=10, then Count=0
    applyStimulus(1'b1, 5'd11, 32'd10, 5'd11);
    checkOutput("bypass_compare", data_o, 32'd10);
    stepClock(1);
    checkOutput("compare_written", compare_o, 32'd10);
    checkOutput("count_inc_during_cmp_wr", count_o, 32'd6);
    applyStimulus(1'b1, 5'd9, 32'd0, 5'd9);
    stepClock(1);
    checkOutput("count_written", count_o, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9);
    stepClock(10);
    checkOutput("count_at_match", count_o, 32'd10);
    checkOutput("timer_before_match_edge", {31'd0, timer_int_o}, 32'd0);
    stepClock(1);
    checkOutput("timer_set", {31'd0, timer_int_o}, 32'd1);
    stepClock(3);
    checkOutput("timer_sticky", {31'd0, timer_int_o}, 32'd1);
    applyStimulus(1'b1, 5'd11, 32'd100, 5'd11);
    stepClock(1);
    checkOutput("timer_cleared", {31'd0, timer_int_o}, 32'd0);
    checkOutput("compare_100", compare_o, 32'd100);

    // Cause masking: IP[15:10] already tracking int_i before the write
    int_i = 6'b000101;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd13);
    stepClock(1);
    checkOutput("cause_ip_track", cause_o, 32'h00001400);
    applyStimulus(1'b1, 5'd13, 32'hFFFFFFFF, 5'd13);
    checkOutput("bypass_cause", data_o, 32'h00C01700);
    stepClock(1);
    checkOutput("cause_masked", cause_o, 32'h00C01700);
    int_i = 6'b100000;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd13);
    stepClock(1);
    checkOutput("cause_int_change", cause_o, 32'h00C08300);

    // EPC bypass and Status write
    applyStimulus(1'b1, 5'd14, 32'hDEADBEEF, 5'd14);
    checkOutput("bypass_epc", data_o, 32'hDEADBEEF);
    stepClock(1);
    checkOutput("epc_written", epc_o, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd12, 32'h0000FF01, 5'd14);
    checkOutput("no_bypass_other_addr", data_o, 32'hDEADBEEF);
    stepClock(1);
    checkOutput("status_written", status_o, 32'h0000FF01);

    // Read-only and unmapped writes
    applyStimulus(1'b1, 5'd15, 32'h12345678, 5'd15);
    checkOutput("read_prid_during_wr", data_o, 32'h004C0102);
    stepClock(1);
    applyStimulus(1'b1, 5'd16, 32'h12345678, 5'd16);
    checkOutput("read_config_during_wr", data_o, 32'h00008000);
    stepClock(1);
    applyStimulus(1'b1, 5'd3, 32'h12345678, 5'd3);
    checkOutput("read_unmapped_during_wr", data_o, 32'd0);
    stepClock(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3);
    checkOutput("read_unmapped", data_o, 32'd0);
    checkOutput("prid_unchanged", prid_o, 32'h004C0102);
    checkOutput("config_unchanged", config_o, 32'h00008000);
    checkOutput("status_kept", status_o, 32'h0000FF01);
    checkOutput("epc_kept", epc_o, 32'hDEADBEEF);

    // Count wrap
    applyStimulus(1'b1, 5'd9, 32'hFFFFFFFE, 5'd9);
    stepClock(1);
    checkOutput("count_fffffffe", count_o, 32'hFFFFFFFE);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9);
    stepClock(1);
    checkOutput("count_ffffffff", count_o, 32'hFFFFFFFF);
    stepClock(1);
    checkOutput("count_wrap_0", count_o, 32'd0);

    // Count write on a matching cycle: match uses the old Count
    applyStimulus(1'b1, 5'd9, 32'd100, 5'd9);
    stepClock(1);
    checkOutput("count_eq_compare", count_o, 32'd100);
    checkOutput("timer_not_yet", {31'd0, timer_int_o}, 32'd0);
    applyStimulus(1'b1, 5'd9, 32'd5, 5'd9);
    stepClock(1);
    checkOutput("count_override", count_o, 32'd5);
    checkOutput("timer_set_on_count_wr", {31'd0, timer_int_o}, 32'd1);

    // Compare write on a matching cycle: clear wins
    applyStimulus(1'b1, 5'd9, 32'd100, 5'd9);
    stepClock(1);
    checkOutput("timer_still_set", {31'd0, timer_int_o}, 32'd1);
    applyStimulus(1'b1, 5'd11, 32'd200, 5'd11);
    stepClock(1);
    checkOutput("timer_clear_beats_match", {31'd0, timer_int_o}, 32'd0);
    checkOutput("count_after_cmp_wr", count_o, 32'd101);

    // Reset mid-operation drops a concurrent write
    rst = 1'b1;
    applyStimulus(1'b1, 5'd14, 32'h00000055, 5'd14);
    checkOutput("rst_data_no_bypass", data_o, 32'd0);
    stepClock(1);
    checkOutput("midrst_epc", epc_o, 32'd0);
    checkOutput("midrst_status", status_o, 32'h10000000);
    checkOutput("midrst_compare", compare_o, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9);
    stepClock(1);
    checkOutput("no_match_when_compare_0", {31'd0, timer_int_o}, 32'd0);
    checkOutput("count_after_midrst", count_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
